alu_issue_stage: RTL and testbench

Pipeline stage directly upstream of the 32-bit ALU. It accepts decoded instructions over a valid/ready handshake and selects operand2 (register or immediate). It holds instructions in a 2-entry buffer and presents operand1/operand2/opCode/destination to the ALU. It also snoops the registered writeback bus so operands held or captured here are never stale.

---
 rtl/alu_issue_stage.sv | 160 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: 2-entry issue buffer ahead of the 32-bit ALU with operand2 select.
// Define ALU_ISSUE_BYPASS_EN to forward and snoop the writeback bus into buffered operands.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int OPW   = 6,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [OPW-1:0]   inOp,
  input  logic [AW-1:0]    inRs1Addr,
  input  logic [AW-1:0]    inRs2Addr,
  input  logic [WIDTH-1:0] inRs1Val,
  input  logic [WIDTH-1:0] inRs2Val,
  input  logic [WIDTH-1:0] inImm,
  input  logic             inUseImm,
  input  logic [AW-1:0]    inRdAddr,
  input  logic             wbValid,
  input  logic [AW-1:0]    wbAddr,
  input  logic [WIDTH-1:0] wbData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] operand1,
  output logic [WIDTH-1:0] operand2,
  output logic [OPW-1:0]   opCode,
  output logic [AW-1:0]    outRdAddr,
  output logic             outIllegal
);

  logic [WIDTH-1:0] op1Q [2];
  logic [WIDTH-1:0] op2Q [2];
  logic [WIDTH-1:0] op1Next [2];
  logic [WIDTH-1:0] op2Next [2];
  logic [AW-1:0]    rdQ [2];
  logic [OPW-1:0]   opQ [2];
  logic [1:0]       illQ;
  logic [1:0]       count;
  logic [1:0]       countNext;
  logic             head;
  logic             tail;
  logic             push;
  logic             pop;
  logic             showPtr;
  logic [WIDTH-1:0] capOp1;
  logic [WIDTH-1:0] capOp2;

`ifdef ALU_ISSUE_BYPASS_EN
  logic [AW-1:0] rs1Q [2];
  logic [AW-1:0] rs2Q [2];
  logic [1:0]    immQ;
  logic [1:0]    live;
`else
  logic unusedBypass;
  assign unusedBypass = ^{wbValid, wbAddr, wbData, inRs1Addr, inRs2Addr};
`endif

  assign outValid = (count != 2'd0);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  // With the buffer empty, keep showing the entry popped last so the ALU inputs hold.
  assign showPtr    = (count == 2'd0) ? ~head : head;
  assign operand1   = op1Q[showPtr];
  assign operand2   = op2Q[showPtr];
  assign opCode     = opQ[showPtr];
  assign outRdAddr  = rdQ[showPtr];
  assign outIllegal = illQ[showPtr];

  always_comb begin
    countNext = count;
    case ({push, pop})
      2'b10:   countNext = count + 2'd1;
      2'b01:   countNext = count - 2'd1;
      default: countNext = count;
    endcase
  end

`ifdef ALU_ISSUE_BYPASS_EN
  // An entry popped this cycle is leaving, so it must not absorb a snoop hit.
  always_comb begin
    live = 2'b00;
    for (int i = 0; i < 2; i++) begin
      live[i] = ((count == 2'd2) || ((count == 2'd1) && (head == 1'(i))))
                && !(pop && (head == 1'(i)));
    end
  end
`endif

  always_comb begin
    capOp1 = inRs1Val;
    capOp2 = inUseImm ? inImm : inRs2Val;
    for (int i = 0; i < 2; i++) begin
      op1Next[i] = op1Q[i];
      op2Next[i] = op2Q[i];
    end
`ifdef ALU_ISSUE_BYPASS_EN
    if (wbValid && (wbAddr == inRs1Addr) && (inRs1Addr != '0)) capOp1 = wbData;
    if (wbValid && !inUseImm && (wbAddr == inRs2Addr) && (inRs2Addr != '0)) capOp2 = wbData;
    for (int i = 0; i < 2; i++) begin
      if (live[i] && wbValid && (wbAddr == rs1Q[i]) && (rs1Q[i] != '0)) op1Next[i] = wbData;
      if (live[i] && wbValid && !immQ[i] && (wbAddr == rs2Q[i]) && (rs2Q[i] != '0))
        op2Next[i] = wbData;
    end
`endif
    if (push) begin
      op1Next[tail] = capOp1;
      op2Next[tail] = capOp2;
    end
  end

  // inReady is registered from the next occupancy so it never depends on outReady combinationally.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count   <= 2'd0;
      head    <= 1'b0;
      tail    <= 1'b0;
      inReady <= 1'b1;
      illQ    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        op1Q[i] <= '0;
        op2Q[i] <= '0;
        rdQ[i]  <= '0;
        opQ[i]  <= '0;
      end
    end else begin
      count   <= countNext;
      inReady <= (countNext < 2'd2);
      for (int i = 0; i < 2; i++) begin
        op1Q[i] <= op1Next[i];
        op2Q[i] <= op2Next[i];
      end
      if (push) begin
        tail       <= ~tail;
        rdQ[tail]  <= inRdAddr;
        opQ[tail]  <= inOp;
        illQ[tail] <= (inOp > OPW'(4));
      end
      if (pop) head <= ~head;
    end
  end

`ifdef ALU_ISSUE_BYPASS_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      immQ <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rs1Q[i] <= '0;
        rs2Q[i] <= '0;
      end
    end else if (push) begin
      rs1Q[tail] <= inRs1Addr;
      rs2Q[tail] <= inRs2Addr;
      immQ[tail] <= inUseImm;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed bench for alu_issue_stage with a queue-based model.
// The model follows ALU_ISSUE_BYPASS_EN the same way the design build does.
module tb_alu_issue_stage;

  logic        clk;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic [5:0]  inOp;
  logic [4:0]  inRs1Addr;
  logic [4:0]  inRs2Addr;
  logic [31:0] inRs1Val;
  logic [31:0] inRs2Val;
  logic [31:0] inImm;
  logic        inUseImm;
  logic [4:0]  inRdAddr;
  logic        wbValid;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        outValid;
  logic        outReady;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [5:0]  opCode;
  logic [4:0]  outRdAddr;
  logic        outIllegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        useImm;
    logic [4:0]  rd;
    logic [5:0]  op;
  } exp_t;

  exp_t expQ[$];
  exp_t lastOut;

  alu_issue_stage dut (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady), .inOp(inOp),
    .inRs1Addr(inRs1Addr), .inRs2Addr(inRs2Addr), .inRs1Val(inRs1Val), .inRs2Val(inRs2Val),
    .inImm(inImm), .inUseImm(inUseImm), .inRdAddr(inRdAddr), .wbValid(wbValid),
    .wbAddr(wbAddr), .wbData(wbData), .outValid(outValid), .outReady(outReady),
    .operand1(operand1), .operand2(operand2), .opCode(opCode), .outRdAddr(outRdAddr),
    .outIllegal(outIllegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

`ifdef ALU_ISSUE_BYPASS_EN
  function automatic bit wbHit(input logic [4:0] a);
    return wbValid && (wbAddr == a) && (a != 5'd0);
  endfunction
`endif

  // Reference model: a plain queue of in-flight instructions, checked and updated at each negedge.
  always @(negedge clk) begin
    if (!resetN) begin
      expQ.delete();
      lastOut = '{default: '0};
    end else begin
      checkOutput("outValid", 32'(outValid), 32'(expQ.size() != 0));
      checkOutput("inReady", 32'(inReady), 32'(expQ.size() < 2));
      if (expQ.size() != 0) begin
        checkOutput("operand1", operand1, expQ[0].op1);
        checkOutput("operand2", operand2, expQ[0].op2);
        checkOutput("opCode", 32'(opCode), 32'(expQ[0].op));
        checkOutput("outRdAddr", 32'(outRdAddr), 32'(expQ[0].rd));
        checkOutput("outIllegal", 32'(outIllegal), 32'(expQ[0].op > 6'd4));
        if (outValid && outReady) lastOut = expQ.pop_front();
      end else begin
        checkOutput("holdOperand1", operand1, lastOut.op1);
        checkOutput("holdOperand2", operand2, lastOut.op2);
        checkOutput("holdOpCode", 32'(opCode), 32'(lastOut.op));
        checkOutput("holdRdAddr", 32'(outRdAddr), 32'(lastOut.rd));
      end
`ifdef ALU_ISSUE_BYPASS_EN
      foreach (expQ[i]) begin
        if (wbHit(expQ[i].rs1)) expQ[i].op1 = wbData;
        if (!expQ[i].useImm && wbHit(expQ[i].rs2)) expQ[i].op2 = wbData;
      end
`endif
      if (inValid && inReady) begin
        exp_t e;
        e.op1    = inRs1Val;
        e.op2    = inUseImm ? inImm : inRs2Val;
        e.rs1    = inRs1Addr;
        e.rs2    = inRs2Addr;
        e.useImm = inUseImm;
        e.rd     = inRdAddr;
        e.op     = inOp;
`ifdef ALU_ISSUE_BYPASS_EN
        if (wbHit(inRs1Addr)) e.op1 = wbData;
        if (!inUseImm && wbHit(inRs2Addr)) e.op2 = wbData;
`endif
        expQ.push_back(e);
      end
    end
  end

  task automatic setInstr(input logic [5:0] op, input logic [4:0] r1a, input logic [31:0] r1v,
                          input logic [4:0] r2a, input logic [31:0] r2v, input logic [31:0] imm,
                          input logic useImm, input logic [4:0] rd);
    inOp = op; inRs1Addr = r1a; inRs1Val = r1v; inRs2Addr = r2a; inRs2Val = r2v;
    inImm = imm; inUseImm = useImm; inRdAddr = rd;
  endtask

  task automatic setWb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wbValid = v; wbAddr = a; wbData = d;
  endtask

  task automatic applyStimulus(input logic v, input logic r);
    inValid  = v;
    outReady = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] expOp;
    resetN = 1'b0;
    inValid = 1'b0;
    outReady = 1'b0;
    setInstr(6'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    setWb(1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;

    // Single instruction straight through.
    setInstr(6'd0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'd3);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);

    // Three back-to-back pushes against a stalled ALU, then drain.
    setInstr(6'd1, 5'd9, 32'h11, 5'd10, 32'h12, 32'd0, 1'b0, 5'd4);
    applyStimulus(1'b1, 1'b0);
    setInstr(6'd2, 5'd11, 32'h21, 5'd12, 32'h22, 32'd0, 1'b0, 5'd5);
    applyStimulus(1'b1, 1'b0);
    setInstr(6'd3, 5'd13, 32'h31, 5'd14, 32'h32, 32'd0, 1'b0, 5'd6);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    inValid = 1'b0;
    repeat (4) applyStimulus(1'b0, 1'b1);

    // Immediate operand must not be replaced by a writeback hit on rs2.
    setInstr(6'd4, 5'd1, 32'd1, 5'd4, 32'd3, 32'hFFFFFFF0, 1'b1, 5'd7);
    setWb(1'b1, 5'd4, 32'd9);
    applyStimulus(1'b1, 1'b0);
    inValid = 1'b0;
    setWb(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checkOutput("immKept", operand2, 32'hFFFFFFF0);
    @(posedge clk); #1;
    repeat (2) applyStimulus(1'b0, 1'b1);

    // Capture forwarding on rs1, and register 0 never forwarded.
    setInstr(6'd1, 5'd6, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 5'd8);
    setWb(1'b1, 5'd6, 32'd100);
    applyStimulus(1'b1, 1'b0);
    inValid = 1'b0;
    setWb(1'b0, 5'd0, 32'd0);
`ifdef ALU_ISSUE_BYPASS_EN
    expOp = 32'd100;
`else
    expOp = 32'd1;
`endif
    @(negedge clk);
    checkOutput("captureFwd", operand1, expOp);
    @(posedge clk); #1;
    repeat (2) applyStimulus(1'b0, 1'b1);
    setInstr(6'd1, 5'd0, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 5'd8);
    setWb(1'b1, 5'd0, 32'd100);
    applyStimulus(1'b1, 1'b0);
    inValid = 1'b0;
    setWb(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checkOutput("reg0NoFwd", operand1, 32'd1);
    @(posedge clk); #1;
    repeat (2) applyStimulus(1'b0, 1'b1);

    // Snoop into both stalled entries reading register 8.
    setInstr(6'd2, 5'd1, 32'd3, 5'd8, 32'd2, 32'd0, 1'b0, 5'd9);
    applyStimulus(1'b1, 1'b0);
    setInstr(6'd3, 5'd2, 32'd4, 5'd8, 32'd2, 32'd0, 1'b0, 5'd10);
    applyStimulus(1'b1, 1'b0);
    inValid = 1'b0;
    setWb(1'b1, 5'd8, 32'd55);
    applyStimulus(1'b0, 1'b0);
    setWb(1'b0, 5'd0, 32'd0);
`ifdef ALU_ISSUE_BYPASS_EN
    expOp = 32'd55;
`else
    expOp = 32'd2;
`endif
    @(negedge clk);
    checkOutput("snoopHead", operand2, expOp);
    @(posedge clk); #1;
    repeat (3) applyStimulus(1'b0, 1'b1);

    // Illegal opcode passes through; then async reset while full.
    setInstr(6'b000111, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 5'd11);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    inValid = 1'b0;
    #2 resetN = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(outValid), 32'd0);
    checkOutput("asyncRstReady", 32'(inReady), 32'd1);
    checkOutput("asyncRstOperand1", operand1, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 resetN = 1'b1;

    // Randomized traffic with a small register window to provoke hits.
    for (int n = 0; n < 800; n++) begin
      setInstr(6'($urandom_range(0, 9)), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)),
               5'($urandom));
      setWb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end
    inValid = 1'b0;
    setWb(1'b0, 5'd0, 32'd0);
    repeat (4) applyStimulus(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
